tx_stream_fifo: RTL and testbench

Parametrised transmit buffer between the compressor output (`golden` byte stream) and the UART transmitter. It replaces the single-byte buffer stage with a DEPTH-entry FIFO, almost-full back-pressure, overflow detection and optional per-frame checksum insertion. Bytes pushed by the encoder are released to the UART one at a time: each release is a `write_TDR` pulse, and the next release waits for `trans_done`.

---
 rtl/tx_stream_fifo_pkg.sv | 17 +
 rtl/tx_stream_fifo_if.sv | 24 ++
 rtl/tx_stream_fifo_mem.sv | 53 +++++
 rtl/tx_stream_fifo.sv | 126 ++++++++++++
 tb/tb_tx_stream_fifo.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/tx_stream_fifo_pkg.sv
// Shared types and default parameters for the UART transmit stream FIFO.
package tx_stream_pkg;

  localparam int unsigned DEF_W         = 8;
  localparam int unsigned DEF_DEPTH     = 16;
  localparam int unsigned DEF_LOGDEPTH  = 4;
  localparam int unsigned DEF_AF_MARGIN = 2;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    WAIT,
    CSUM_LOAD,
    CSUM_WAIT
  } tx_state_t;

endpackage

// File: rtl/tx_stream_fifo_if.sv
// Encoder-side push bus and UART-side load/done handshake of the transmit FIFO.
interface tx_stream_fifo_if
  import tx_stream_pkg::*;
#(
  parameter int unsigned W = DEF_W
);
  logic [W-1:0] data_in;
  logic         data_enable;
  logic         frame_end;
  logic         stall;
  logic         trans_done;
  logic         write_TDR;
  logic [W-1:0] data_out;

  modport master (
    output data_in, data_enable, frame_end, trans_done,
    input  stall, write_TDR, data_out
  );

  modport slave (
    input  data_in, data_enable, frame_end, trans_done,
    output stall, write_TDR, data_out
  );
endinterface

// File: rtl/tx_stream_fifo_mem.sv
// Circular-buffer storage for the transmit FIFO: pointers, occupancy, full/empty.
module tx_fifo_mem
  import tx_stream_pkg::*;
#(
  parameter int unsigned EW       = DEF_W,
  parameter int unsigned DEPTH    = DEF_DEPTH,
  parameter int unsigned LOGDEPTH = DEF_LOGDEPTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                push,
  input  logic                pop,
  input  logic [EW-1:0]       wdata,
  output logic [EW-1:0]       rdata,
  output logic [LOGDEPTH:0]   count,
  output logic                full,
  output logic                empty
);

  logic [EW-1:0]       mem [DEPTH];
  logic [LOGDEPTH-1:0] wr_ptr;
  logic [LOGDEPTH-1:0] rd_ptr;
  logic                do_push;
  logic                do_pop;

  assign full    = (32'(count) == DEPTH);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // DEPTH is a power of two, so pointer wrap is the natural roll-over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/tx_stream_fifo.sv
// Transmit FIFO between encoder and UART; TX_STREAM_FIFO_CHECKSUM_EN appends a
// per-frame XOR byte after each byte pushed with frame_end.
module tx_stream_fifo
  import tx_stream_pkg::*;
#(
  parameter int unsigned W         = DEF_W,
  parameter int unsigned DEPTH     = DEF_DEPTH,
  parameter int unsigned LOGDEPTH  = DEF_LOGDEPTH,
  parameter int unsigned AF_MARGIN = DEF_AF_MARGIN
) (
  input  logic              clk,
  input  logic              rst,
  tx_stream_fifo_if.slave   bus,
  output logic              idle,
  output logic [LOGDEPTH:0] count,
  output logic              overflow
);

`ifdef TX_STREAM_FIFO_CHECKSUM_EN
  localparam int unsigned EW = W + 1;
`else
  localparam int unsigned EW = W;
`endif

  logic [EW-1:0] wdata;
  logic [EW-1:0] rdata;
  logic          full;
  logic          empty;
  logic          pop;
  logic          write_tdr;
  logic [W-1:0]  data_out_q;
  tx_state_t     state_q;
  tx_state_t     state_d;

  tx_fifo_mem #(
    .EW       (EW),
    .DEPTH    (DEPTH),
    .LOGDEPTH (LOGDEPTH)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.data_enable),
    .pop   (pop),
    .wdata (wdata),
    .rdata (rdata),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef TX_STREAM_FIFO_CHECKSUM_EN
  logic [W-1:0] csum_q;
  logic         tag_q;

  assign wdata = {bus.frame_end, bus.data_in};

  // The in-flight byte is already folded in at its LOAD edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
      tag_q  <= 1'b0;
    end else begin
      if (state_q == IDLE && !empty) tag_q <= rdata[W];
      if (state_q == LOAD)           csum_q <= csum_q ^ data_out_q;
      else if (state_q == CSUM_LOAD) csum_q <= '0;
    end
  end
`else
  logic unused_frame_end;
  assign unused_frame_end = bus.frame_end;
  assign wdata            = bus.data_in;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      data_out_q <= '0;
      overflow   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.data_enable && full) overflow <= 1'b1;
      // data_out is captured on the edge entering a load state.
      if (state_q == IDLE && !empty) data_out_q <= rdata[W-1:0];
`ifdef TX_STREAM_FIFO_CHECKSUM_EN
      else if (state_q == WAIT && bus.trans_done && tag_q) data_out_q <= csum_q;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    write_tdr = 1'b0;
    case (state_q)
      IDLE: if (!empty) state_d = LOAD;
      LOAD: begin
        write_tdr = 1'b1;
        pop       = 1'b1;
        state_d   = WAIT;
      end
      WAIT: begin
        if (bus.trans_done) begin
`ifdef TX_STREAM_FIFO_CHECKSUM_EN
          state_d = tag_q ? CSUM_LOAD : IDLE;
`else
          state_d = IDLE;
`endif
        end
      end
`ifdef TX_STREAM_FIFO_CHECKSUM_EN
      CSUM_LOAD: begin
        write_tdr = 1'b1;
        state_d   = CSUM_WAIT;
      end
      CSUM_WAIT: if (bus.trans_done) state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  assign bus.write_TDR = write_tdr;
  assign bus.data_out  = data_out_q;
  assign bus.stall     = (32'(count) >= DEPTH - AF_MARGIN);
  assign idle          = (state_q == IDLE) && empty;

endmodule

// File: tb/tb_tx_stream_fifo.sv
// Scoreboard bench for tx_stream_fifo: directed pushes queue expected UART bytes,
// a monitor compares data_out on every write_TDR, a responder returns trans_done.
module tb_tx_stream_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       idle;
  logic [4:0] count;
  logic       overflow;

  logic       td_auto   = 1'b0;
  logic       td_manual = 1'b0;
  bit         uart_en   = 1'b0;
  int unsigned uart_delay = 1;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  exp_q [$];

  tx_stream_fifo_if #(.W(8)) bus ();

  assign bus.trans_done = td_auto | td_manual;

  tx_stream_fifo #(
    .W         (8),
    .DEPTH     (16),
    .LOGDEPTH  (4),
    .AF_MARGIN (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .idle     (idle),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
  endtask

  // Caller is at a negedge; returns at the next negedge with data_enable low.
  task automatic push_one(input logic [7:0] b, input bit fe, input bit accepted);
    bus.data_in     = b;
    bus.frame_end   = fe;
    bus.data_enable = 1'b1;
    if (accepted) exp_q.push_back(b);
    @(negedge clk);
    bus.data_enable = 1'b0;
    bus.frame_end   = 1'b0;
  endtask

  task automatic pulse_done();
    td_manual = 1'b1;
    @(negedge clk);
    td_manual = 1'b0;
  endtask

  task automatic drain(input string name, input int unsigned limit);
    int unsigned n = 0;
    while (!(idle === 1'b1 && exp_q.size() == 0) && n < limit) begin
      @(negedge clk);
      n++;
    end
    check(name, {31'd0, (idle === 1'b1 && exp_q.size() == 0)}, 32'd1);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " write_TDR"}, {31'd0, bus.write_TDR}, 32'd0);
    check({tag, " data_out"},  {24'd0, bus.data_out},  32'd0);
    check({tag, " stall"},     {31'd0, bus.stall},     32'd0);
    check({tag, " idle"},      {31'd0, idle},          32'd1);
    check({tag, " count"},     {27'd0, count},         32'd0);
    check({tag, " overflow"},  {31'd0, overflow},      32'd0);
  endtask

  // UART model: trans_done uart_delay cycles after a write_TDR, while enabled.
  initial begin : uart_model
    bit          busy = 1'b0;
    int unsigned wait_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      td_auto = 1'b0;
      if (rst || td_manual) busy = 1'b0;
      else if (bus.write_TDR) begin
        busy     = 1'b1;
        wait_cnt = 0;
      end else if (busy && uart_en) begin
        wait_cnt++;
        if (wait_cnt >= uart_delay) begin
          td_auto = 1'b1;
          busy    = 1'b0;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(negedge clk);
      if (bus.write_TDR === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected write_TDR", 32'd1, 32'd0);
        else check("data_out", {24'd0, bus.data_out}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_checks + 1);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    int unsigned exp_count;
    bus.data_in     = '0;
    bus.data_enable = 1'b1;  // must be ignored while rst is high
    bus.frame_end   = 1'b0;
    repeat (3) @(negedge clk);
    bus.data_enable = 1'b0;
    rst = 1'b0;
    check_reset_state("reset");

    // Single byte latency and idle return.
    push_one(8'hA5, 1'b0, 1'b1);
    check("t1 count", {27'd0, count}, 32'd1);
    check("t1 early write_TDR", {31'd0, bus.write_TDR}, 32'd0);
    check("t1 idle busy", {31'd0, idle}, 32'd0);
    @(negedge clk);
    check("t1 write_TDR", {31'd0, bus.write_TDR}, 32'd1);
    @(negedge clk);
    check("t1 write_TDR pulse", {31'd0, bus.write_TDR}, 32'd0);
    check("t1 count after pop", {27'd0, count}, 32'd0);
    check("t1 idle in WAIT", {31'd0, idle}, 32'd0);
    repeat (4) @(negedge clk);
    pulse_done();
    check("t1 idle after done", {31'd0, idle}, 32'd1);

    // Fill with trans_done withheld: first byte goes in flight, so 17 fill the FIFO.
    uart_en = 1'b0;
    for (int unsigned k = 1; k <= 17; k++) begin
      push_one(8'(k - 1), 1'b0, 1'b1);
      exp_count = (k <= 2) ? k : k - 1;
      check("t2 count", {27'd0, count}, exp_count);
      check("t2 stall", {31'd0, bus.stall}, {31'd0, exp_count >= 14});
    end
    check("t2 overflow clear", {31'd0, overflow}, 32'd0);
    push_one(8'hFF, 1'b0, 1'b0);
    check("t2 overflow set", {31'd0, overflow}, 32'd1);
    check("t2 count full", {27'd0, count}, 32'd16);
    uart_en    = 1'b1;
    uart_delay = 3;
    drain("t2 drain", 2000);
    check("t2 stall released", {31'd0, bus.stall}, 32'd0);
    check("t2 overflow sticky", {31'd0, overflow}, 32'd1);

    // Simultaneous push and pop at count 3.
    uart_en = 1'b0;
    for (int unsigned k = 0; k < 4; k++) push_one(8'(8'h20 + k), 1'b0, 1'b1);
    check("t3 count before", {27'd0, count}, 32'd3);
    pulse_done();
    @(negedge clk);
    check("t3 in LOAD", {31'd0, bus.write_TDR}, 32'd1);
    push_one(8'h24, 1'b0, 1'b1);
    check("t3 count same", {27'd0, count}, 32'd3);
    uart_en    = 1'b1;
    uart_delay = 1;
    drain("t3 drain", 2000);

    // Pointer wrap: 40 bytes streamed through.
    for (int unsigned k = 0; k < 40; k++) begin
      push_one(8'(8'h40 + k), 1'b0, 1'b1);
      repeat (2) @(negedge clk);
    end
    drain("t4 wrap drain", 4000);

    // Spurious trans_done in IDLE.
    pulse_done();
    for (int unsigned k = 0; k < 3; k++) begin
      check("t5 write_TDR", {31'd0, bus.write_TDR}, 32'd0);
      check("t5 idle", {31'd0, idle}, 32'd1);
      @(negedge clk);
    end
    check("t5 count", {27'd0, count}, 32'd0);

    // Reset while in WAIT with 5 queued.
    uart_en = 1'b0;
    for (int unsigned k = 0; k < 6; k++) push_one(8'(8'h30 + k), 1'b0, 1'b1);
    check("t6 count queued", {27'd0, count}, 32'd5);
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("t6 mid-reset");
    exp_q.delete();
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("t6 still idle", {31'd0, idle}, 32'd1);
    uart_en = 1'b1;
    push_one(8'h3C, 1'b0, 1'b1);
    drain("t6 drain", 2000);

`ifdef TX_STREAM_FIFO_CHECKSUM_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_one(8'h12, 1'b0, 1'b1);
    push_one(8'h34, 1'b0, 1'b1);
    push_one(8'h56, 1'b1, 1'b1);
    exp_q.push_back(8'h70);
    drain("t7 frame1", 2000);
    push_one(8'h01, 1'b0, 1'b1);
    push_one(8'h02, 1'b1, 1'b1);
    exp_q.push_back(8'h03);
    drain("t7 frame2", 2000);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
